// File: rtl/stopwatch_display_if.sv
// Display-side bundle for the stopwatch display: the time fields and blink
// select going in, and the multiplexed seven-segment drive coming out.
interface stopwatch_display_if;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] blink_sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    // Driver of the time fields / consumer of the segment drive
    modport master (
        output minutes,
        output seconds,
        output blink_sel,
        input  seg,
        input  dp,
        input  an
    );

    // The display block itself
    modport slave (
        input  minutes,
        input  seconds,
        input  blink_sel,
        output seg,
        output dp,
        output an
    );
endinterface

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed common-anode display of MM.SS. Both fields are
// captured once per scan frame so a frame never mixes old and new values;
// either field can be blinked for adjust mode. All outputs are registered.
module stopwatch_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_display_if.slave  disp
);
    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic [1:0]         digit_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_on_reg;
    logic [5:0]         min_q_reg;
    logic [5:0]         sec_q_reg;
    logic               first_reg;
    logic [3:0]         an_reg;
    logic [6:0]         seg_reg;
    logic               dp_reg;

    logic               scan_wrap;
    logic               blink_wrap;
    logic               frame_end;
    logic [5:0]         min_cur;
    logic [5:0]         sec_cur;
    logic [3:0]         an_next;
    logic [6:0]         digit_code [4];

    // Active-low g..a pattern for one decimal digit
    function automatic logic [6:0] seg_decode(input logic [5:0] d);
        logic [6:0] s;
        case (d)
            6'd0:    s = 7'b1000000;
            6'd1:    s = 7'b1111001;
            6'd2:    s = 7'b0100100;
            6'd3:    s = 7'b0110000;
            6'd4:    s = 7'b0011001;
            6'd5:    s = 7'b0010010;
            6'd6:    s = 7'b0000010;
            6'd7:    s = 7'b1111000;
            6'd8:    s = 7'b0000000;
            6'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign scan_wrap  = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
    assign blink_wrap = (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1));
    assign frame_end  = scan_wrap && (digit_reg == 2'd3);

    // The first slot after reset belongs to the frame being captured right
    // then, so it shows the live inputs instead of the cleared snapshot.
    assign min_cur = first_reg ? disp.minutes : min_q_reg;
    assign sec_cur = first_reg ? disp.seconds : sec_q_reg;

    // Per-digit segment pattern and anode enable; digits 0/1 are seconds,
    // 2/3 are minutes, even digits are ones and odd digits are tens.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam int FIELD = gi / 2;
            logic [5:0] field;
            logic [5:0] val;
            logic [6:0] code;

            // Choose field and decimal place, then apply dash/blink overrides
            always_comb begin
                field = (FIELD == 0) ? sec_cur : min_cur;
                val   = ((gi % 2) == 0) ? (field % 6'd10) : (field / 6'd10);
                if (!blink_on_reg && disp.blink_sel[FIELD])
                    code = SEG_BLANK;
                else if (field > 6'd59)
                    code = SEG_DASH;
                else
                    code = seg_decode(val);
            end

            assign digit_code[gi] = code;
            assign an_next[gi]    = (digit_reg != 2'(gi));
        end
    endgenerate

    // Scan timing: digit dwell counter and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_reg <= '0;
            digit_reg    <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt_reg <= '0;
            digit_reg    <= digit_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
        end
    end

    // Blink phase: toggles every BLINK_DIV clocks, starts in the lit phase
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (blink_wrap) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        end
    end

    // Frame snapshot: captured on the first clock after reset and at every
    // frame boundary, so mid-frame input changes stay invisible
    always_ff @(posedge clk) begin
        if (reset) begin
            min_q_reg <= 6'd0;
            sec_q_reg <= 6'd0;
            first_reg <= 1'b1;
        end else begin
            first_reg <= 1'b0;
            if (first_reg || frame_end) begin
                min_q_reg <= disp.minutes;
                sec_q_reg <= disp.seconds;
            end
        end
    end

    // Registered display drive for the digit currently being scanned
    always_ff @(posedge clk) begin
        if (reset) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= an_next;
            seg_reg <= digit_code[digit_reg];
            dp_reg  <= (digit_reg != 2'd2);
        end
    end

    assign disp.an  = an_reg;
    assign disp.seg = seg_reg;
    assign disp.dp  = dp_reg;
endmodule
